bulls_cows_controller: RTL

- Game sequencer for the two-player Bulls & Cows datapath.
- Captures each player's 4-digit secret, alternates guesses between players, and computes bulls/cows against the opponent's secret.
- Detects a win and keeps per-player scores.
- Emits state code, results and pulses that the display manager maps to the 7-segment digit codes; this block does no display encoding.

---
 rtl/bulls_cows_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bulls_cows_controller.sv
// Two-player Bulls & Cows game sequencer: secret capture, guess scoring,
// win detection and per-player scoreboard.
module bulls_cows_controller #(
  parameter int SCORE_W  = 4,
  parameter int TURN_MAX = 99
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               confirm,
  input  logic [15:0]        switches,
  output logic [2:0]         state,
  output logic [2:0]         bulls,
  output logic [2:0]         cows,
  output logic               result_valid,
  output logic               error,
  output logic               winner,
  output logic [SCORE_W-1:0] score_j1,
  output logic [SCORE_W-1:0] score_j2,
  output logic [6:0]         turn_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SECRET1  = 3'd1,
    S_SECRET2  = 3'd2,
    S_GUESS1   = 3'd3,
    S_GUESS2   = 3'd4,
    S_WIN      = 3'd5
  } state_t;

  state_t      st;
  logic        confirm_q;
  logic [15:0] secret_j1;
  logic [15:0] secret_j2;

  logic        conf_pulse;
  logic        entry_ok;
  logic [15:0] opp_secret;
  logic [2:0]  g_bulls;
  logic [2:0]  g_cows;
  logic [6:0]  turn_inc;

  assign state = st;

  function automatic logic valid_entry(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      for (int j = i + 1; j < 4; j++)
        if (v[4*i +: 4] == v[4*j +: 4]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [2:0] bulls_of(
    input logic [15:0] g,
    input logic [15:0] s
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++)
      if (g[4*i +: 4] == s[4*i +: 4]) n = n + 3'd1;
    return n;
  endfunction

  // A cow is a non-bull guess digit found at another secret position.
  function automatic logic [2:0] cows_of(
    input logic [15:0] g,
    input logic [15:0] s
  );
    logic [2:0] n;
    logic       hit;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      hit = 1'b0;
      for (int j = 0; j < 4; j++)
        if (j != i && g[4*i +: 4] == s[4*j +: 4]) hit = 1'b1;
      if (g[4*i +: 4] != s[4*i +: 4] && hit) n = n + 3'd1;
    end
    return n;
  endfunction

  always_comb begin
    conf_pulse = confirm & ~confirm_q;
    entry_ok   = valid_entry(switches);
    opp_secret = (st == S_GUESS2) ? secret_j1 : secret_j2;
    g_bulls    = bulls_of(switches, opp_secret);
    g_cows     = cows_of(switches, opp_secret);
    turn_inc   = (turn_count < 7'(TURN_MAX)) ? turn_count + 7'd1
                                             : turn_count;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st           <= S_IDLE;
      confirm_q    <= 1'b0;
      secret_j1    <= '0;
      secret_j2    <= '0;
      bulls        <= '0;
      cows         <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      winner       <= 1'b0;
      score_j1     <= '0;
      score_j2     <= '0;
      turn_count   <= '0;
    end else begin
      confirm_q    <= confirm;
      result_valid <= 1'b0;
      error        <= 1'b0;
      case (st)
        S_IDLE: st <= S_SECRET1;
        S_SECRET1, S_SECRET2: begin
          if (conf_pulse) begin
            if (!entry_ok) begin
              error <= 1'b1;
            end else if (st == S_SECRET1) begin
              secret_j1 <= switches;
              st        <= S_SECRET2;
            end else begin
              secret_j2 <= switches;
              st        <= S_GUESS1;
            end
          end
        end
        S_GUESS1, S_GUESS2: begin
          if (conf_pulse) begin
            if (!entry_ok) begin
              error <= 1'b1;
            end else begin
              bulls        <= g_bulls;
              cows         <= g_cows;
              result_valid <= 1'b1;
              turn_count   <= turn_inc;
              if (g_bulls == 3'd4) begin
                st <= S_WIN;
                if (st == S_GUESS1) begin
                  winner <= 1'b0;
                  if (!(&score_j1)) score_j1 <= score_j1 + 1'b1;
                end else begin
                  winner <= 1'b1;
                  if (!(&score_j2)) score_j2 <= score_j2 + 1'b1;
                end
              end else begin
                st <= (st == S_GUESS1) ? S_GUESS2 : S_GUESS1;
              end
            end
          end
        end
        S_WIN: begin
          if (conf_pulse) begin
            st         <= S_SECRET1;
            secret_j1  <= '0;
            secret_j2  <= '0;
            bulls      <= '0;
            cows       <= '0;
            turn_count <= '0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
